// File: rtl/operand_sequencer.sv
// Register-file operand sequencer that fetches two operands, drives an external ALU and writes back. Optional OPSEQ_ZERO_REG_EN hardwires R0 to zero.
// Latency: handshake at T, alu_en at T+2, done at T+3, ready again at T+4; instr_ready drops while busy or while ld_en is asserted.
module operand_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   input  logic        ld_en,
   input  logic [3:0]  ld_addr,
   input  logic [31:0] ld_data,
   input  logic [3:0]  dbg_addr,
   output logic [31:0] dbg_data,
   output logic        alu_en,
   output logic [2:0]  alu_ctrl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_v,
   input  logic        alu_c,
   input  logic        alu_n,
   input  logic        alu_z,
   output logic [3:0]  flags,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   state_t      state;
   logic [31:0] rf [16];
   logic [2:0]  ir_op;
   logic [3:0]  ir_rd;
   logic [3:0]  ir_rs1;
   logic [3:0]  ir_rs2;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        op_live;
   logic        ld_we;
   logic        wb_we;
   logic        unused_instr_bit;

   assign unused_instr_bit = instr[0];

   // NOP and the undefined opcode walk the FSM without touching the ALU, RF or flags
   assign op_live = (ir_op != 3'b000) && (ir_op != 3'b111);

`ifdef OPSEQ_ZERO_REG_EN
   assign dbg_data = (dbg_addr == 4'd0) ? 32'd0 : rf[dbg_addr];
   assign rs1_val  = (ir_rs1 == 4'd0)   ? 32'd0 : rf[ir_rs1];
   assign rs2_val  = (ir_rs2 == 4'd0)   ? 32'd0 : rf[ir_rs2];
   assign ld_we    = (state == S_IDLE) && ld_en && (ld_addr != 4'd0);
   assign wb_we    = (state == S_WB) && op_live && (ir_rd != 4'd0);
`else
   assign dbg_data = rf[dbg_addr];
   assign rs1_val  = rf[ir_rs1];
   assign rs2_val  = rf[ir_rs2];
   assign ld_we    = (state == S_IDLE) && ld_en;
   assign wb_we    = (state == S_WB) && op_live;
`endif

   assign instr_ready = reset_n && (state == S_IDLE) && !ld_en;
   assign busy        = (state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         ir_op    <= 3'd0;
         ir_rd    <= 4'd0;
         ir_rs1   <= 4'd0;
         ir_rs2   <= 4'd0;
         alu_a    <= 32'd0;
         alu_b    <= 32'd0;
         alu_ctrl <= 3'd0;
         alu_en   <= 1'b0;
         done     <= 1'b0;
         flags    <= 4'd0;
         for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ld_we) rf[ld_addr] <= ld_data;
               if (instr_valid && instr_ready) begin
                  ir_op  <= instr[15:13];
                  ir_rd  <= instr[12:9];
                  ir_rs1 <= instr[8:5];
                  ir_rs2 <= instr[4:1];
                  state  <= S_READ;
               end
            end
            S_READ: begin
               alu_a    <= rs1_val;
               alu_b    <= rs2_val;
               alu_ctrl <= ir_op;
               alu_en   <= op_live;
               state    <= S_EXEC;
            end
            S_EXEC: begin
               alu_en <= 1'b0;
               done   <= 1'b1;
               state  <= S_WB;
            end
            S_WB: begin
               // operands were latched in READ, so rd aliasing rs1/rs2 is harmless here
               if (wb_we) rf[ir_rd] <= alu_result;
               if (op_live) flags <= {alu_n, alu_z, alu_c, alu_v};
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: vector table, scoreboard of write-backs, reset/load corner sequences.
module tb_operand_sequencer;

`ifdef OPSEQ_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        ld_en;
   logic [3:0]  ld_addr;
   logic [31:0] ld_data;
   logic [3:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        alu_en;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        alu_v, alu_c, alu_n, alu_z;
   logic [3:0]  flags;
   logic        done;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  rd, rs1, rs2;
      logic [31:0] a, b, val;
      logic [3:0]  fl;
   } vec_t;

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] val;
      logic [3:0]  fl;
      int          t;
   } sb_t;

   vec_t vt [10];
   sb_t  sb [$];

   operand_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .alu_en(alu_en), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z),
      .flags(flags), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External ALU: 1 add, 2 sub (c = borrow), 3 and, 4 or, 5 xor, 6 shl; other codes return a marker value
   logic [32:0] sum;
   always_comb begin
      sum        = 33'd0;
      alu_result = 32'hDEAD_BEEF;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      case (alu_ctrl)
         3'd1: begin
            sum        = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = sum[31:0];
            alu_c      = sum[32];
            alu_v      = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         3'd2: begin
            alu_result = alu_a - alu_b;
            alu_c      = (alu_a < alu_b);
            alu_v      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         3'd3: alu_result = alu_a & alu_b;
         3'd4: alu_result = alu_a | alu_b;
         3'd5: alu_result = alu_a ^ alu_b;
         3'd6: alu_result = alu_a << alu_b[4:0];
         default: alu_result = 32'hDEAD_BEEF;
      endcase
      alu_n = alu_result[31];
      alu_z = (alu_result == 32'd0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic rdchk(input string nm, input logic [3:0] addr, input logic [31:0] exp);
      dbg_addr = addr;
      #1;
      chk(nm, dbg_data, exp);
   endtask

   task automatic load(input logic [3:0] addr, input logic [31:0] data);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = addr; ld_data = data;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [31:0] val, input logic [3:0] fl);
      int  n;
      sb_t e;
      @(negedge clk);
      ld_en       = 1'b0;
      instr_valid = 1'b1;
      instr       = {op, rd, rs1, rs2, 1'b1};
      #1;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("handshake_ready", {31'd0, instr_ready}, 32'd1);
      e.rd = rd; e.val = val; e.fl = fl; e.t = cyc;
      sb.push_back(e);
   endtask

   task automatic finish(input logic live, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic ld_in_exec);
      int  n;
      sb_t e;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("read_busy", {31'd0, busy}, 32'd1);
      chk("read_alu_en", {31'd0, alu_en}, 32'd0);
      @(negedge clk);
      chk("exec_alu_en", {31'd0, alu_en}, {31'd0, live});
      if (live) begin
         chk("exec_alu_a", alu_a, a);
         chk("exec_alu_b", alu_b, b);
         chk("exec_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, op});
      end
      if (ld_in_exec) begin
         ld_en = 1'b1; ld_addr = 4'd5; ld_data = 32'hDEAD_0005;
      end
      @(negedge clk);
      ld_en = 1'b0;
      n = 0;
      while (!done && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
      e.rd = 4'd0; e.val = 32'd0; e.fl = 4'd0; e.t = 0;
      if (sb.size() > 0) e = sb.pop_front();
      chk("done_latency", cyc - e.t, 32'd3);
      chk("wb_alu_en", {31'd0, alu_en}, 32'd0);
      dbg_addr = e.rd;
      @(negedge clk);
      chk("post_done_low", {31'd0, done}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("post_ready", {31'd0, instr_ready}, 32'd1);
      chk("post_flags", {28'd0, flags}, {28'd0, e.fl});
      chk("post_rd_value", dbg_data, e.val);
   endtask

   task automatic run(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] val, input logic [3:0] fl);
      issue(op, rd, rs1, rs2, val, fl);
      finish((op != 3'd0) && (op != 3'd7), a, b, op, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0;
      int n;
      reset_n = 1'b0; instr_valid = 1'b0; instr = 16'd0;
      ld_en = 1'b0; ld_addr = 4'd0; ld_data = 32'd0; dbg_addr = 4'd0;

      vt[0] = '{3'd1, 4'd3,  4'd1,  4'd2,  32'd5,          32'd3,          32'd8,          4'b0000};
      vt[1] = '{3'd2, 4'd4,  4'd1,  4'd2,  32'd3,          32'd3,          32'd0,          4'b0100};
      vt[2] = '{3'd1, 4'd5,  4'd6,  4'd7,  32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0110};
      vt[3] = '{3'd1, 4'd6,  4'd2,  4'd3,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1001};
      vt[4] = '{3'd2, 4'd7,  4'd4,  4'd5,  32'd2,          32'd5,          32'hFFFF_FFFD,  4'b1010};
      vt[5] = '{3'd3, 4'd8,  4'd9,  4'd10, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  4'b1000};
      vt[6] = '{3'd4, 4'd9,  4'd11, 4'd12, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  4'b0000};
      vt[7] = '{3'd5, 4'd10, 4'd13, 4'd14, 32'hAAAA_AAAA,  32'hAAAA_AAAA,  32'd0,          4'b0100};
      vt[8] = '{3'd6, 4'd11, 4'd14, 4'd15, 32'd1,          32'd4,          32'h10,         4'b0000};
      vt[9] = '{3'd1, 4'd1,  4'd1,  4'd2,  32'd10,         32'd20,         32'd30,         4'b0000};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_flags", {28'd0, flags}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rst_release_ready", {31'd0, instr_ready}, 32'd1);

      // table-driven operations
      for (int i = 0; i < 10; i++) begin
         load(vt[i].rs1, vt[i].a);
         load(vt[i].rs2, vt[i].b);
         run(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].a, vt[i].b, vt[i].val, vt[i].fl);
      end

      // zero result then NOP and undefined opcode keep flags and RF
      load(4'd1, 32'd3);
      load(4'd2, 32'd3);
      run(3'd2, 4'd7, 4'd1, 4'd2, 32'd3, 32'd3, 32'd0, 4'b0100);
      load(4'd8, 32'h0000_1234);
      run(3'd0, 4'd8, 4'd1, 4'd2, 32'd3, 32'd3, 32'h0000_1234, 4'b0100);
      run(3'd7, 4'd8, 4'd1, 4'd2, 32'd3, 32'd3, 32'h0000_1234, 4'b0100);

      // load and instruction offered together: load wins, instruction taken next cycle
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 4'd9; ld_data = 32'h0000_CAFE;
      instr_valid = 1'b1; instr = {3'd1, 4'd10, 4'd9, 4'd9, 1'b0};
      #1;
      chk("collide_ready", {31'd0, instr_ready}, 32'd0);
      c0 = cyc;
      issue(3'd1, 4'd10, 4'd9, 4'd9, 32'h0001_95FC, 4'b0000);
      chk("collide_accept_cycle", sb[$].t - c0, 32'd1);
      finish(1'b1, 32'h0000_CAFE, 32'h0000_CAFE, 3'd1, 1'b0);
      rdchk("collide_load_written", 4'd9, 32'h0000_CAFE);

      // load during EXEC is ignored
      load(4'd5, 32'h8000_0000);
      issue(3'd1, 4'd11, 4'd5, 4'd5, 32'd0, 4'b0111);
      finish(1'b1, 32'h8000_0000, 32'h8000_0000, 3'd1, 1'b1);
      rdchk("exec_load_ignored", 4'd5, 32'h8000_0000);

      // reset during EXEC aborts the instruction
      issue(3'd1, 4'd12, 4'd5, 4'd5, 32'd0, 4'b0111);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      chk("abort_exec_alu_en", {31'd0, alu_en}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_alu_en", {31'd0, alu_en}, 32'd0);
      chk("abort_flags", {28'd0, flags}, 32'd0);
      chk("abort_ready", {31'd0, instr_ready}, 32'd0);
      chk("abort_alu_a", alu_a, 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("abort_release_ready", {31'd0, instr_ready}, 32'd1);
      n = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("abort_no_done", n, 32'd0);
      for (int r = 0; r < 16; r++) rdchk("abort_rf_zero", r[3:0], 32'd0);

      // register 0 behaviour
      load(4'd0, 32'hFFFF_FFFF);
      rdchk("r0_after_load", 4'd0, ZR ? 32'd0 : 32'hFFFF_FFFF);
      load(4'd13, 32'h0000_000F);
      load(4'd14, 32'h0000_00F0);
      run(3'd2, 4'd0, 4'd13, 4'd14, 32'h0000_000F, 32'h0000_00F0,
          ZR ? 32'd0 : 32'hFFFF_FF1F, 4'b1010);
      run(3'd4, 4'd15, 4'd0, 4'd13, ZR ? 32'd0 : 32'hFFFF_FF1F, 32'h0000_000F,
          ZR ? 32'h0000_000F : 32'hFFFF_FF1F, ZR ? 4'b0000 : 4'b1000);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
